// File: rtl/hit_detector.sv
`default_nettype none
// ============================================================================
//  Module   : hit_detector
//  Purpose  : Debounces per-hole buttons, serialises presses and scores them
//             against the active-mole mask. Optional macro MISS_LOCKOUT_EN
//             adds a penalty lockout after a miss.
//  Revision : 1.0  initial release
// ============================================================================
module hit_detector #(
    parameter int N_HOLES         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int IDX_W           = 4,
    parameter int LOCKOUT_CYCLES  = 50_000_000
) (
    input  logic               clkIn,
    input  logic               reset,
    input  logic               game_active,
    input  logic [N_HOLES-1:0] btn_raw,
    input  logic [N_HOLES-1:0] mole_active,
    output logic               player_scored,
    output logic [N_HOLES-1:0] mole_hit,
    output logic [IDX_W-1:0]   hit_index,
    output logic               miss,
    output logic               locked
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_HOLES-1:0] w_press;
    logic [N_HOLES-1:0] r_pending;
    logic [N_HOLES-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_locked;
    logic               w_service;
    logic               w_hit;

    // Per-button synchroniser and debouncer; a press is the cycle the
    // debounced level flips from 0 to 1.
    for (genvar g = 0; g < N_HOLES; g++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_db;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clkIn or negedge reset) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_db    <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= btn_raw[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt <= '0;
                    r_db  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[g] = r_sync2 & ~r_db & (r_cnt == c_CNT_LAST);
    end

    // Lowest-index pending hole wins; isolate its bit and encode it.
    assign w_grant   = r_pending & (~r_pending + N_HOLES'(1));
    assign w_service = game_active & ~w_locked & (|r_pending);
    assign w_hit     = |(w_grant & mole_active);

    always_comb begin
        w_idx = '0;
        for (int j = N_HOLES - 1; j >= 0; j--) begin
            if (r_pending[j]) begin
                w_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else if (!game_active || w_locked) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_press;
        end
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            player_scored <= 1'b0;
            miss          <= 1'b0;
            mole_hit      <= '0;
            hit_index     <= '0;
        end else begin
            player_scored <= w_service & w_hit;
            miss          <= w_service & ~w_hit;
            mole_hit      <= (w_service && w_hit) ? w_grant : '0;
            if (w_service) begin
                hit_index <= w_idx;
            end
        end
    end

`ifdef MISS_LOCKOUT_EN
    localparam int c_LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

    logic [c_LOCK_W-1:0] r_lock_cnt;

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            r_lock_cnt <= '0;
        end else if (!game_active) begin
            r_lock_cnt <= '0;
        end else if (w_service && !w_hit) begin
            r_lock_cnt <= c_LOCK_W'(LOCKOUT_CYCLES);
        end else if (r_lock_cnt != '0) begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
        end
    end

    assign w_locked = |r_lock_cnt;
`else
    // Lockout length only matters when the lockout feature is built in.
    localparam bit c_LOCK_CFG = (LOCKOUT_CYCLES >= 0);
    assign w_locked = 1'b0 & c_LOCK_CFG;
`endif

    assign locked = w_locked;

endmodule
`default_nettype wire
